fb_scaler_out: RTL and testbench

// - Sits between the GBA framebuffer RAM and the HDMI transmitter pins, downstream of the 640x480 VGA timing generator.
// - Tracks the generator's raster, issues framebuffer read addresses and centres a 2x-scaled 240x160 image.
// - Expands RGB555 read data to RGB888, paints a border colour outside the image window, and delays sync/DE to match.

---
 rtl/fb_scaler_out.sv | 164 ++++++++++++++++
 tb/tb_fb_scaler_out.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scaler_out.sv
`timescale 1ns/1ps
// Purpose: tracks the VGA raster, issues framebuffer reads and centres an integer-scaled image with RGB555->RGB888 expansion and border fill.
// Latency: i_de/i_hs/i_vs -> o_de/o_hs/o_vs is 2 i_ce strobes; read data is sampled one strobe after o_rdaddr is issued.
// Backpressure: none, free-running video pipe. FB_SCANLINE_EN darkens the last replica line of every source row.
module fb_scaler_out #(
    parameter int          SRC_W      = 240,
    parameter int          SRC_H      = 160,
    parameter int          SCALE      = 2,
    parameter int          H_OFF      = 80,
    parameter int          V_OFF      = 80,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ce,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [14:0] i_rgb15,
    output logic [15:0] o_rdaddr,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [23:0] o_rgb24,
    output logic        o_in_win
);
    localparam int            CW       = 12;
    localparam logic [CW-1:0] H_LO     = CW'(H_OFF);
    localparam logic [CW-1:0] H_HI     = CW'(H_OFF + SRC_W * SCALE);
    localparam logic [CW-1:0] V_LO     = CW'(V_OFF);
    localparam logic [CW-1:0] V_HI     = CW'(V_OFF + SRC_H * SCALE);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam int            COLW     = $clog2(SRC_W + 1);
    localparam logic [1:0]    SUB_MAX  = 2'(SCALE - 1);
    localparam logic [15:0]   ROW_STEP = 16'(SRC_W);
    localparam logic [15:0]   ROW_MAX  = 16'((SRC_H - 1) * SRC_W);

    typedef enum logic {WAIT_VS = 1'b0, ACTIVE = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            vs_q, de_q;
    logic            vs_rise, de_fall;
    logic [CW-1:0]   hcnt, vcnt;
    logic [COLW-1:0] col;
    logic [1:0]      hsub, vsub;
    logic [15:0]     row_base;
    logic            h_in, v_in, pix_win;
    logic            s1_de, s1_hs, s1_vs, s1_win;
    logic [23:0]     pix_rgb;

    function automatic logic [7:0] exp5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    assign vs_rise = i_ce & i_vs & ~vs_q;
    assign de_fall = i_ce & de_q & ~i_de;
    assign h_in    = (hcnt >= H_LO) && (hcnt < H_HI);
    assign v_in    = (vcnt >= V_LO) && (vcnt < V_HI);
    assign pix_win = (state_q == ACTIVE) & i_de & h_in & v_in;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= WAIT_VS;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (vs_rise) state_d = ACTIVE;
    end

    // Raster tracking; a vsync rise takes priority over a coincident DE fall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_q     <= 1'b0;
            de_q     <= 1'b0;
            hcnt     <= '0;
            vcnt     <= '0;
            col      <= '0;
            hsub     <= '0;
            vsub     <= '0;
            row_base <= '0;
        end else if (i_ce) begin
            vs_q <= i_vs;
            de_q <= i_de;
            if (vs_rise) begin
                hcnt     <= '0;
                vcnt     <= '0;
                col      <= '0;
                hsub     <= '0;
                vsub     <= '0;
                row_base <= '0;
            end else if (de_fall) begin
                hcnt <= '0;
                col  <= '0;
                hsub <= '0;
                if (vcnt != CNT_MAX) vcnt <= vcnt + CW'(1);
                if (v_in) begin
                    if (vsub == SUB_MAX) begin
                        vsub <= '0;
                        if (row_base < ROW_MAX) row_base <= row_base + ROW_STEP;
                    end else begin
                        vsub <= vsub + 2'd1;
                    end
                end
            end else if (i_de) begin
                if (hcnt != CNT_MAX) hcnt <= hcnt + CW'(1);
                if (pix_win) begin
                    if (hsub == SUB_MAX) begin
                        hsub <= '0;
                        col  <= col + COLW'(1);
                    end else begin
                        hsub <= hsub + 2'd1;
                    end
                end
            end
        end
    end

`ifdef FB_SCANLINE_EN
    localparam logic SL_ON = (SCALE > 1);
    logic s1_dark;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  s1_dark <= 1'b0;
        else if (i_ce) s1_dark <= pix_win & SL_ON & (vsub == SUB_MAX);
    end

    always_comb begin
        pix_rgb = {exp5(i_rgb15[14:10]), exp5(i_rgb15[9:5]), exp5(i_rgb15[4:0])};
        if (s1_dark) pix_rgb = {1'b0, pix_rgb[23:17], 1'b0, pix_rgb[15:9], 1'b0, pix_rgb[7:1]};
    end
`else
    always_comb begin
        pix_rgb = {exp5(i_rgb15[14:10]), exp5(i_rgb15[9:5]), exp5(i_rgb15[4:0])};
    end
`endif

    // DE is suppressed until the first vsync after reset so a partial frame never reaches the pins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_de    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_win   <= 1'b0;
            o_rdaddr <= '0;
            o_de     <= 1'b0;
            o_hs     <= 1'b0;
            o_vs     <= 1'b0;
            o_in_win <= 1'b0;
            o_rgb24  <= '0;
        end else if (i_ce) begin
            s1_de    <= i_de & (state_q == ACTIVE);
            s1_hs    <= i_hs;
            s1_vs    <= i_vs;
            s1_win   <= pix_win;
            if (pix_win) o_rdaddr <= row_base + 16'(col);
            o_de     <= s1_de;
            o_hs     <= s1_hs;
            o_vs     <= s1_vs;
            o_in_win <= s1_win;
            o_rgb24  <= !s1_de ? 24'h000000 : (s1_win ? pix_rgb : BORDER_RGB);
        end
    end
endmodule

// File: tb/tb_fb_scaler_out.sv
`timescale 1ns/1ps
// Directed bench for fb_scaler_out on a shrunken raster (6x4 source, 2x scale, 18-pixel lines, 12-line frames).
// A per-pixel reference derives addresses by division and colours by bit expansion; spot vectors pin exact colours.
module tb_fb_scaler_out;
    localparam int          SRC_W  = 6;
    localparam int          SRC_H  = 4;
    localparam int          SCALE  = 2;
    localparam int          H_OFF  = 3;
    localparam int          V_OFF  = 2;
    localparam logic [23:0] BORDER = 24'h123456;
    localparam int          LINE_W = 18;
    localparam int          BLANK  = 4;
    localparam int          LINES  = 12;
    localparam int          AMAX   = SRC_W * SRC_H;
`ifdef FB_SCANLINE_EN
    localparam logic [23:0] WHITE_ODD = 24'h7F7F7F;
    localparam logic [23:0] GREY_ODD  = 24'h424242;
`else
    localparam logic [23:0] WHITE_ODD = 24'hFFFFFF;
    localparam logic [23:0] GREY_ODD  = 24'h848484;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0;
    logic [14:0] rgb15, ram_q, const_rgb;
    logic        ram_const;
    logic [15:0] rdaddr;
    logic        o_hs, o_vs, o_de, o_in_win;
    logic [23:0] o_rgb24;

    always #10 clk = ~clk;
    always_ff @(posedge clk) ram_q <= rdaddr[14:0];
    assign rgb15 = ram_const ? const_rgb : ram_q;

    fb_scaler_out #(.SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .H_OFF(H_OFF), .V_OFF(V_OFF),
                    .BORDER_RGB(BORDER)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_hs(hs), .i_vs(vs), .i_de(de), .i_rgb15(rgb15),
        .o_rdaddr(rdaddr), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_rgb24(o_rgb24), .o_in_win(o_in_win));

    typedef struct { bit de; bit hs; bit vs; bit win; logic [23:0] rgb; int y; int x; } exp_t;
    typedef struct { int f; int y; int x; logic [23:0] rgb; bit win; } vec_t;

    int          checks = 0, errors = 0;
    int          y, x, cap_sel, over_cnt;
    bit          active, de_prev, vs_prev, count_en;
    exp_t        pend;
    logic [15:0] last_addr;
    int          addr_cnt [AMAX];
    logic [23:0] cap_rgb [2][LINES][LINE_W];
    logic        cap_win [2][LINES][LINE_W];
    vec_t        vec [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] expand(input logic [14:0] c, input bit dark);
        logic [7:0] r, g, b;
        r = {c[14:10], c[14:12]};
        g = {c[9:5], c[9:7]};
        b = {c[4:0], c[4:2]};
        if (dark) begin
            r = r >> 1;
            g = g >> 1;
            b = b >> 1;
        end
        return {r, g, b};
    endfunction

    task automatic model_reset();
        y = 0; x = 0; active = 0; de_prev = 0; vs_prev = 0; last_addr = '0;
        pend = '{de: 0, hs: 0, vs: 0, win: 0, rgb: 24'h0, y: 0, x: 0};
    endtask

    // One pixel strobe: predict, pulse i_ce, compare, advance the reference raster.
    task automatic strobe();
        exp_t cur;
        int   a;
        bit   dark;
        cur.de  = de & active;
        cur.hs  = hs;
        cur.vs  = vs;
        cur.y   = y;
        cur.x   = x;
        cur.win = active && de && x >= H_OFF && x < H_OFF + SRC_W * SCALE
                  && y >= V_OFF && y < V_OFF + SRC_H * SCALE;
        a    = cur.win ? ((y - V_OFF) / SCALE) * SRC_W + (x - H_OFF) / SCALE : 0;
        dark = 1'b0;
`ifdef FB_SCANLINE_EN
        dark = cur.win && (SCALE > 1) && ((y - V_OFF) % SCALE == SCALE - 1);
`endif
        cur.rgb = !cur.de ? 24'h0 : (cur.win ? expand(ram_const ? const_rgb : 15'(a), dark) : BORDER);

        ce = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
        if (cur.win) last_addr = 16'(a);
        chk("rdaddr", 32'(rdaddr), 32'(last_addr));
        if (count_en && cur.win) begin
            if (int'(rdaddr) < AMAX) addr_cnt[int'(rdaddr)]++;
            else over_cnt++;
        end
        chk("o_de", 32'(o_de), 32'(pend.de));
        chk("o_hs", 32'(o_hs), 32'(pend.hs));
        chk("o_vs", 32'(o_vs), 32'(pend.vs));
        chk("o_in_win", 32'(o_in_win), 32'(pend.win));
        chk("o_rgb24", 32'(o_rgb24), 32'(pend.rgb));
        if (cap_sel >= 0 && cap_sel < 2 && pend.de && pend.y < LINES && pend.x < LINE_W) begin
            cap_rgb[cap_sel][pend.y][pend.x] = o_rgb24;
            cap_win[cap_sel][pend.y][pend.x] = o_in_win;
        end

        if (vs && !vs_prev) begin
            y = 0; x = 0; active = 1;
        end else begin
            if (de_prev && !de) y++;
            x = de ? x + 1 : 0;
        end
        de_prev = de;
        vs_prev = vs;
        pend    = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int de_len, input int vs_at);
        for (int i = 0; i < de_len; i++) begin
            de = 1'b1; hs = 1'b0; vs = 1'b0;
            strobe();
        end
        for (int i = 0; i < BLANK; i++) begin
            de = 1'b0;
            hs = (i == 1 || i == 2);
            vs = (vs_at >= 0) && (i == vs_at || i == vs_at + 1);
            strobe();
        end
    endtask

    task automatic run_frame(input int short_line);
        for (int l = 0; l < LINES; l++)
            run_line((l == short_line) ? 9 : LINE_W, (l == LINES - 1) ? 2 : -1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rdaddr", 32'(rdaddr), 32'h0);
        chk("rst_o_de", 32'(o_de), 32'h0);
        chk("rst_o_hs", 32'(o_hs), 32'h0);
        chk("rst_o_vs", 32'(o_vs), 32'h0);
        chk("rst_o_in_win", 32'(o_in_win), 32'h0);
        chk("rst_o_rgb24", 32'(o_rgb24), 32'h0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{f: 0, y: 2,  x: 3,  rgb: 24'hFFFFFF, win: 1};
        vec[1]  = '{f: 0, y: 0,  x: 0,  rgb: BORDER,     win: 0};
        vec[2]  = '{f: 0, y: 2,  x: 2,  rgb: BORDER,     win: 0};
        vec[3]  = '{f: 0, y: 2,  x: 15, rgb: BORDER,     win: 0};
        vec[4]  = '{f: 0, y: 9,  x: 14, rgb: WHITE_ODD,  win: 1};
        vec[5]  = '{f: 0, y: 10, x: 5,  rgb: BORDER,     win: 0};
        vec[6]  = '{f: 0, y: 1,  x: 8,  rgb: BORDER,     win: 0};
        vec[7]  = '{f: 0, y: 3,  x: 3,  rgb: WHITE_ODD,  win: 1};
        vec[8]  = '{f: 0, y: 3,  x: 16, rgb: BORDER,     win: 0};
        vec[9]  = '{f: 1, y: 4,  x: 7,  rgb: 24'h848484, win: 1};
        vec[10] = '{f: 1, y: 5,  x: 7,  rgb: GREY_ODD,   win: 1};
        vec[11] = '{f: 1, y: 0,  x: 17, rgb: BORDER,     win: 0};

        model_reset();
        ram_const = 1'b0; const_rgb = '0; cap_sel = -1; count_en = 1'b0; over_cnt = 0;
        for (int i = 0; i < AMAX; i++) addr_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();

        // Release reset mid-line with DE high; nothing is shown until a vsync arrives.
        de = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_line(7, -1);
        run_line(LINE_W, -1);
        run_line(LINE_W, 2);

        count_en = 1'b1;
        run_frame(-1);
        count_en = 1'b0;
        for (int i = 0; i < AMAX; i++) chk($sformatf("addr_hits_%0d", i), 32'(addr_cnt[i]), 32'(SCALE * SCALE));
        chk("addr_overrange", 32'(over_cnt), 32'h0);

        ram_const = 1'b1;
        const_rgb = 15'h7FFF; cap_sel = 0; run_frame(-1);
        const_rgb = 15'h4210; cap_sel = 1; run_frame(-1);
        cap_sel = -1; ram_const = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("vec%0d_rgb", i), 32'(cap_rgb[vec[i].f][vec[i].y][vec[i].x]), 32'(vec[i].rgb));
            chk($sformatf("vec%0d_win", i), 32'(cap_win[vec[i].f][vec[i].y][vec[i].x]), 32'(vec[i].win));
        end

        // Short first window line, then a vsync coincident with a DE fall mid-frame.
        run_frame(V_OFF);
        for (int l = 0; l <= 5; l++) run_line(LINE_W, (l == 5) ? 0 : -1);
        run_frame(-1);

        // Asynchronous reset inside the image window.
        for (int l = 0; l < 4; l++) run_line(LINE_W, -1);
        for (int i = 0; i < 6; i++) begin
            de = 1'b1; hs = 1'b0; vs = 1'b0;
            strobe();
        end
        chk("pre_rst_in_win", 32'(o_in_win), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_line(LINE_W - 6, -1);
        run_line(LINE_W, -1);
        run_line(LINE_W, 2);
        run_frame(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
